servant_ram_arb: RTL and testbench

Two-master Wishbone arbiter placed in front of the single-port servant RAM. It lets the CPU memory bus (master 0) and the debug-module system bus (master 1) share one RAM port. It sequences one transaction at a time with round-robin fairness. A watchdog terminates any transaction the RAM never acknowledges.

---
 rtl/servant_ram_arb.sv | 133 +++++++++++++
 tb/tb_servant_ram_arb.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/servant_ram_arb.sv
// Two-master Wishbone arbiter in front of the single-port servant RAM.
// One transaction at a time, round-robin on contention, watchdog abort on a missing ack.
module servant_ram_arb #(
    parameter int aw      = 8,
    parameter int TIMEOUT = 15
) (
    input  logic          i_wb_clk,
    input  logic          i_wb_rst_n,

    input  logic [aw-1:2] i_m0_adr,
    input  logic [31:0]   i_m0_dat,
    input  logic [3:0]    i_m0_sel,
    input  logic          i_m0_we,
    input  logic          i_m0_cyc,
    output logic [31:0]   o_m0_rdt,
    output logic          o_m0_ack,
    output logic          o_m0_err,

    input  logic [aw-1:2] i_m1_adr,
    input  logic [31:0]   i_m1_dat,
    input  logic [3:0]    i_m1_sel,
    input  logic          i_m1_we,
    input  logic          i_m1_cyc,
    output logic [31:0]   o_m1_rdt,
    output logic          o_m1_ack,
    output logic          o_m1_err,

    output logic [aw-1:2] o_ram_adr,
    output logic [31:0]   o_ram_dat,
    output logic [3:0]    o_ram_sel,
    output logic          o_ram_we,
    output logic          o_ram_cyc,
    input  logic [31:0]   i_ram_rdt,
    input  logic          i_ram_ack,

    output logic          dbg_busy
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t     state, state_nxt;
    logic       gnt, gnt_nxt;
    logic       last, last_nxt;
    logic [7:0] tmo, tmo_nxt;

    logic busy;
    logic gnt_cyc;
    logic tmo_hit;

    assign busy    = (state == BUSY);
    assign gnt_cyc = gnt ? i_m1_cyc : i_m0_cyc;
    assign tmo_hit = busy && !i_ram_ack && (tmo == TMO_LAST);

    // last resets to 1 so that m0 wins the first tie after reset.
    always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
        if (!i_wb_rst_n) begin
            state <= IDLE;
            gnt   <= 1'b0;
            last  <= 1'b1;
            tmo   <= 8'd0;
        end else begin
            state <= state_nxt;
            gnt   <= gnt_nxt;
            last  <= last_nxt;
            tmo   <= tmo_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt;
        last_nxt  = last;
        tmo_nxt   = tmo;
        case (state)
            IDLE: begin
                tmo_nxt = 8'd0;
                if (i_m0_cyc && i_m1_cyc) begin
                    gnt_nxt   = !last;
                    state_nxt = BUSY;
                end else if (i_m0_cyc) begin
                    gnt_nxt   = 1'b0;
                    state_nxt = BUSY;
                end else if (i_m1_cyc) begin
                    gnt_nxt   = 1'b1;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (i_ram_ack || tmo_hit) begin
                    last_nxt  = gnt;
                    state_nxt = IDLE;
                end else if (!gnt_cyc) begin
                    // Master abandoned its request: drop it silently.
                    state_nxt = IDLE;
                end else begin
                    tmo_nxt = tmo + 8'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Request fields follow gnt only while BUSY; m0 otherwise (don't-care with cyc low).
    always_comb begin
        o_ram_adr = i_m0_adr;
        o_ram_dat = i_m0_dat;
        o_ram_sel = i_m0_sel;
        o_ram_we  = busy && i_m0_we;
        if (busy && gnt) begin
            o_ram_adr = i_m1_adr;
            o_ram_dat = i_m1_dat;
            o_ram_sel = i_m1_sel;
            o_ram_we  = i_m1_we;
        end
    end

    assign o_ram_cyc = busy;

    assign o_m0_rdt = i_ram_rdt;
    assign o_m1_rdt = i_ram_rdt;
    assign o_m0_ack = busy && !gnt && i_ram_ack;
    assign o_m1_ack = busy &&  gnt && i_ram_ack;
    assign o_m0_err = tmo_hit && !gnt;
    assign o_m1_err = tmo_hit &&  gnt;

    assign dbg_busy = busy;

endmodule

// File: tb/tb_servant_ram_arb.sv
// Directed bench for servant_ram_arb: a small registered-ack RAM model behind the
// arbiter and two master drivers, with hand-computed expectations.
module tb_servant_ram_arb;

    localparam int AW      = 8;
    localparam int TIMEOUT = 15;

    logic          clk = 1'b0;
    logic          rst_n;

    logic [AW-1:2] m0_adr, m1_adr;
    logic [31:0]   m0_dat, m1_dat;
    logic [3:0]    m0_sel, m1_sel;
    logic          m0_we, m1_we, m0_cyc, m1_cyc;
    logic [31:0]   m0_rdt, m1_rdt;
    logic          m0_ack, m1_ack, m0_err, m1_err;

    logic [AW-1:2] ram_adr;
    logic [31:0]   ram_dat;
    logic [3:0]    ram_sel;
    logic          ram_we, ram_cyc;
    logic [31:0]   ram_rdt = 32'd0;
    logic          ram_ack;
    logic          dbg_busy;

    logic          ram_ack_r  = 1'b0;
    logic          ram_stub   = 1'b0;
    logic          stale_ack  = 1'b0;
    logic          mem_loaded = 1'b0;
    logic [31:0]   mem [64];

    int            n_cmp = 0;
    int            n_err = 0;
    logic [31:0]   exp_q [$];

    servant_ram_arb #(.aw(AW), .TIMEOUT(TIMEOUT)) dut (
        .i_wb_clk   (clk),
        .i_wb_rst_n (rst_n),
        .i_m0_adr   (m0_adr),
        .i_m0_dat   (m0_dat),
        .i_m0_sel   (m0_sel),
        .i_m0_we    (m0_we),
        .i_m0_cyc   (m0_cyc),
        .o_m0_rdt   (m0_rdt),
        .o_m0_ack   (m0_ack),
        .o_m0_err   (m0_err),
        .i_m1_adr   (m1_adr),
        .i_m1_dat   (m1_dat),
        .i_m1_sel   (m1_sel),
        .i_m1_we    (m1_we),
        .i_m1_cyc   (m1_cyc),
        .o_m1_rdt   (m1_rdt),
        .o_m1_ack   (m1_ack),
        .o_m1_err   (m1_err),
        .o_ram_adr  (ram_adr),
        .o_ram_dat  (ram_dat),
        .o_ram_sel  (ram_sel),
        .o_ram_we   (ram_we),
        .o_ram_cyc  (ram_cyc),
        .i_ram_rdt  (ram_rdt),
        .i_ram_ack  (ram_ack),
        .dbg_busy   (dbg_busy)
    );

    // Clock
    always #5 clk = ~clk;

    // RAM model: ack registered one cycle after cyc is seen, one cycle wide.
    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] dat,
                                          input logic [3:0] sel);
        logic [31:0] w;
        w = old;
        for (int b = 0; b < 4; b++)
            if (sel[b]) w[8*b +: 8] = dat[8*b +: 8];
        return w;
    endfunction

    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'd0;
            mem[0]     <= 32'h0010_0073;
            mem_loaded <= 1'b1;
        end else begin
            ram_ack_r <= 1'b0;
            if (ram_cyc && !ram_ack_r && !ram_stub) begin
                ram_ack_r <= 1'b1;
                ram_rdt   <= mem[ram_adr];
                if (ram_we) mem[ram_adr] <= merge(mem[ram_adr], ram_dat, ram_sel);
            end
        end
    end

    assign ram_ack = ram_ack_r | stale_ack;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, want, $time);
        end
    endtask

    task automatic idle_masters();
        m0_cyc = 1'b0; m1_cyc = 1'b0;
        m0_we  = 1'b0; m1_we  = 1'b0;
        m0_adr = '0;   m1_adr = '0;
        m0_dat = '0;   m1_dat = '0;
        m0_sel = 4'hf; m1_sel = 4'hf;
    endtask

    // Driver: one transaction on master m; returns read data, cycles to ack/err,
    // whether it ended in err, and the other master's ack on that cycle.
    task automatic tx(input int m, input logic we, input logic [AW-1:2] adr,
                      input logic [31:0] dat, input logic [3:0] sel,
                      output logic [31:0] rdt, output int lat,
                      output logic got_err, output logic other_ack);
        logic done;
        @(negedge clk);
        if (m == 0) begin
            m0_adr = adr; m0_dat = dat; m0_sel = sel; m0_we = we; m0_cyc = 1'b1;
        end else begin
            m1_adr = adr; m1_dat = dat; m1_sel = sel; m1_we = we; m1_cyc = 1'b1;
        end
        done = 1'b0; lat = 0; got_err = 1'b0; other_ack = 1'b0; rdt = '0;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
            if (m == 0 && (m0_ack || m0_err)) begin
                done = 1'b1; got_err = m0_err; rdt = m0_rdt; other_ack = m1_ack;
            end else if (m == 1 && (m1_ack || m1_err)) begin
                done = 1'b1; got_err = m1_err; rdt = m1_rdt; other_ack = m0_ack;
            end
        end
        m0_cyc = 1'b0;
        m1_cyc = 1'b0;
        if (!done) check("tx_bound", 32'd0, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        logic [31:0] rdt;
        int          lat;
        logic        got_err, other_ack;
        logic [31:0] exp_m;
        int          n_ack, last_c;
        logic        prev_ack, seen;

        // Reset with both masters requesting
        idle_masters();
        rst_n = 1'b0;
        m0_cyc = 1'b1; m1_cyc = 1'b1; m1_adr = 6'd3;
        repeat (3) @(negedge clk);
        check("rst_ram_cyc", 32'(ram_cyc), 32'd0);
        check("rst_ram_we", 32'(ram_we), 32'd0);
        check("rst_acks", {30'd0, m0_ack, m1_ack}, 32'd0);
        check("rst_errs", {30'd0, m0_err, m1_err}, 32'd0);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            if (m0_ack || m1_ack) begin
                seen = 1'b1;
                check("rst_first_gnt_m0", {30'd0, m0_ack, m1_ack}, 32'b10);
            end
        end
        m0_cyc = 1'b0; m1_cyc = 1'b0;
        if (!seen) check("rst_first_bound", 32'd0, 32'd1);
        idle_masters();
        @(negedge clk);

        // Single read by m0
        tx(0, 1'b0, 6'd0, 32'd0, 4'hf, rdt, lat, got_err, other_ack);
        check("rd_latency", 32'(lat), 32'd2);
        check("rd_data", rdt, 32'h0010_0073);
        check("rd_err", 32'(got_err), 32'd0);
        check("rd_m1_ack", 32'(other_ack), 32'd0);

        // Byte write then read-back by m1
        tx(1, 1'b1, 6'd3, 32'hAABB_CCDD, 4'b0010, rdt, lat, got_err, other_ack);
        check("wr_latency", 32'(lat), 32'd2);
        check("wr_m0_ack", 32'(other_ack), 32'd0);
        tx(1, 1'b0, 6'd3, 32'd0, 4'hf, rdt, lat, got_err, other_ack);
        check("wr_readback", rdt, 32'h0000_CC00);

        // Contention: both hold cyc, expect strict alternation starting at m0
        for (int i = 0; i < 8; i++) exp_q.push_back(32'(i % 2));
        @(negedge clk);
        m0_adr = 6'd0; m0_we = 1'b0; m0_cyc = 1'b1;
        m1_adr = 6'd3; m1_we = 1'b0; m1_cyc = 1'b1;
        n_ack = 0; last_c = 0; prev_ack = 1'b0;
        for (int c = 0; c < 60 && n_ack < 8; c++) begin
            @(negedge clk);
            if (prev_ack) check("cont_gap_cyc", 32'(ram_cyc), 32'd0);
            prev_ack = 1'b0;
            if (m0_ack || m1_ack) begin
                check("cont_single_ack", 32'(m0_ack & m1_ack), 32'd0);
                exp_m = exp_q.pop_front();
                check("cont_order", 32'(m1_ack), exp_m);
                check("cont_rdt", m0_rdt, (exp_m == 32'd1) ? 32'h0000_CC00 : 32'h0010_0073);
                if (n_ack > 0) check("cont_period", 32'(c - last_c), 32'd3);
                last_c   = c;
                n_ack++;
                prev_ack = 1'b1;
            end
        end
        m0_cyc = 1'b0; m1_cyc = 1'b0;
        check("cont_count", 32'(n_ack), 32'd8);
        @(negedge clk);

        // Timeout with a RAM that never acks
        ram_stub = 1'b1;
        tx(1, 1'b0, 6'd5, 32'd0, 4'hf, rdt, lat, got_err, other_ack);
        check("tmo_cycle", 32'(lat), 32'(TIMEOUT));
        check("tmo_err", 32'(got_err), 32'd1);
        check("tmo_m0_ack", 32'(other_ack | m0_err), 32'd0);
        @(negedge clk);
        check("tmo_err_one_cycle", 32'(m1_err), 32'd0);
        check("tmo_idle", 32'(ram_cyc), 32'd0);
        stale_ack = 1'b1;
        #1;
        check("stale_acks", {30'd0, m0_ack, m1_ack}, 32'd0);
        @(negedge clk);
        stale_ack = 1'b0;
        check("stale_still_idle", 32'(ram_cyc), 32'd0);
        ram_stub = 1'b0;
        tx(0, 1'b0, 6'd0, 32'd0, 4'hf, rdt, lat, got_err, other_ack);
        check("post_tmo_latency", 32'(lat), 32'd2);
        check("post_tmo_data", rdt, 32'h0010_0073);

        // Reset asserted during BUSY
        @(negedge clk);
        m0_adr = 6'd0; m0_we = 1'b1; m0_dat = 32'h1234_5678; m0_sel = 4'hf; m0_cyc = 1'b1;
        @(negedge clk);
        check("mid_busy", 32'(ram_cyc), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_cyc_drop", 32'(ram_cyc), 32'd0);
        check("mid_we_drop", 32'(ram_we), 32'd0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("mid_no_ack", {30'd0, m0_ack, m1_ack}, 32'd0);
        end
        idle_masters();
        rst_n = 1'b1;
        // The interrupted write never reached the RAM.
        tx(0, 1'b0, 6'd0, 32'd0, 4'hf, rdt, lat, got_err, other_ack);
        check("mid_recover_latency", 32'(lat), 32'd2);
        check("mid_recover_data", rdt, 32'h0010_0073);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
